csi2tx_pixel_capture: RTL and testbench

Sensor-side capture stage of the CSI-2 TX pixel path. Registers the raw sensor pixel bus and produces the aligned `pixel_data`, `pixel_data_d1`, `pixel_data_vld`, `pixel_cnt` and `sensor_pixel_vld_falling_edge` that feed the per-format pixel-to-byte converters (e.g. YUV422 10-bit p2b) directly downstream. It also counts pixels per line and, optionally, checks line length against a programmed value.

---
 rtl/csi2tx_pixel_capture.sv | 70 +++++++
 tb/tb_csi2tx_pixel_capture.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csi2tx_pixel_capture.sv
// Sensor-side capture stage: registers the raw pixel bus and derives line-aligned count/edge strobes.
// Optional line-length checker enabled by defining CSI2TX_LINE_LEN_CHK_EN.
module csi2tx_pixel_capture (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        capture_enable,
   input  logic        sensor_pixel_vld,
   input  logic [31:0] sensor_pixel_data,
   input  logic [15:0] expected_line_pixels,
   output logic [31:0] pixel_data,
   output logic [31:0] pixel_data_d1,
   output logic        pixel_data_vld,
   output logic [2:0]  pixel_cnt,
   output logic        sensor_pixel_vld_falling_edge,
   output logic [15:0] line_pixel_count,
   output logic        line_done,
   output logic        line_len_err
);

   logic vld_d1;
   logic fall_edge;

   // Decoded purely from registers so the pulse is glitch-free and aligned with pixel_cnt.
   assign fall_edge                     = vld_d1 & ~pixel_data_vld;
   assign sensor_pixel_vld_falling_edge = fall_edge;
   assign line_done                     = fall_edge;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pixel_data       <= '0;
         pixel_data_d1    <= '0;
         pixel_data_vld   <= 1'b0;
         vld_d1           <= 1'b0;
         pixel_cnt        <= '0;
         line_pixel_count <= '0;
      end else if (!capture_enable) begin
         pixel_data       <= '0;
         pixel_data_d1    <= '0;
         pixel_data_vld   <= 1'b0;
         vld_d1           <= 1'b0;
         pixel_cnt        <= '0;
         line_pixel_count <= '0;
      end else begin
         pixel_data     <= sensor_pixel_data;
         pixel_data_vld <= sensor_pixel_vld;
         vld_d1         <= pixel_data_vld;
         if (pixel_data_vld)
            pixel_data_d1 <= pixel_data;

         if (fall_edge)
            pixel_cnt <= '0;
         else if (pixel_data_vld)
            pixel_cnt <= pixel_cnt + 3'd1;

         if (fall_edge)
            line_pixel_count <= '0;
         else if (pixel_data_vld && (line_pixel_count != 16'hFFFF))
            line_pixel_count <= line_pixel_count + 16'd1;
      end
   end

`ifdef CSI2TX_LINE_LEN_CHK_EN
   assign line_len_err = fall_edge & (line_pixel_count != expected_line_pixels);
`else
   logic unused_expected;
   assign unused_expected = ^expected_line_pixels;
   assign line_len_err    = 1'b0;
`endif

endmodule

// File: tb/tb_csi2tx_pixel_capture.sv
// Directed self-checking bench for csi2tx_pixel_capture.
module tb_csi2tx_pixel_capture;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        capture_enable = 1'b0;
   logic        sensor_pixel_vld = 1'b0;
   logic [31:0] sensor_pixel_data = '0;
   logic [15:0] expected_line_pixels = '0;
   logic [31:0] pixel_data;
   logic [31:0] pixel_data_d1;
   logic        pixel_data_vld;
   logic [2:0]  pixel_cnt;
   logic        sensor_pixel_vld_falling_edge;
   logic [15:0] line_pixel_count;
   logic        line_done;
   logic        line_len_err;

   int cmp_cnt = 0;
   int err_cnt = 0;

`ifdef CSI2TX_LINE_LEN_CHK_EN
   localparam logic CHK_EN = 1'b1;
`else
   localparam logic CHK_EN = 1'b0;
`endif

   csi2tx_pixel_capture dut (
      .clk                           (clk),
      .rst_n                         (rst_n),
      .capture_enable                (capture_enable),
      .sensor_pixel_vld              (sensor_pixel_vld),
      .sensor_pixel_data             (sensor_pixel_data),
      .expected_line_pixels          (expected_line_pixels),
      .pixel_data                    (pixel_data),
      .pixel_data_d1                 (pixel_data_d1),
      .pixel_data_vld                (pixel_data_vld),
      .pixel_cnt                     (pixel_cnt),
      .sensor_pixel_vld_falling_edge (sensor_pixel_vld_falling_edge),
      .line_pixel_count              (line_pixel_count),
      .line_done                     (line_done),
      .line_len_err                  (line_len_err)
   );

   always #5 clk = ~clk;

   // Inputs change 1 ns after the rising edge; outputs are observed there too.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      tick();
      cmp_cnt++;
      if ({pixel_data, pixel_data_d1, pixel_data_vld, pixel_cnt, sensor_pixel_vld_falling_edge,
           line_pixel_count, line_done, line_len_err} !== '0) begin
         err_cnt++;
         $display("FAIL reset_state: got data=%h d1=%h vld=%b cnt=%0d edge=%b lpc=%0d, want all 0",
                  pixel_data, pixel_data_d1, pixel_data_vld, pixel_cnt,
                  sensor_pixel_vld_falling_edge, line_pixel_count);
      end
      rst_n = 1'b1;
      capture_enable = 1'b1;
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 3; i++) begin
         sensor_pixel_vld = 1'b1;
         sensor_pixel_data = 32'hA0 + i;
         tick();
      end
      cmp_cnt++;
      if (pixel_data_vld !== 1'b1 || pixel_cnt !== 3'd2) begin
         err_cnt++;
         $display("FAIL pre_reset_line: got vld=%b cnt=%0d, want vld=1 cnt=2", pixel_data_vld, pixel_cnt);
      end
      #2 rst_n = 1'b0;
      #1;
      cmp_cnt++;
      if ({pixel_data, pixel_data_d1, pixel_data_vld, pixel_cnt, sensor_pixel_vld_falling_edge,
           line_pixel_count, line_done, line_len_err} !== '0) begin
         err_cnt++;
         $display("FAIL async_reset: got data=%h d1=%h vld=%b cnt=%0d lpc=%0d, want all 0",
                  pixel_data, pixel_data_d1, pixel_data_vld, pixel_cnt, line_pixel_count);
      end
      sensor_pixel_vld = 1'b0;
      #1 rst_n = 1'b1;
      tick();
   endtask

   task automatic test_line8();
      for (int i = 0; i < 8; i++) begin
         sensor_pixel_vld = 1'b1;
         sensor_pixel_data = 32'h100 + i;
         tick();
         cmp_cnt++;
         if (pixel_data !== 32'h100 + i || pixel_data_vld !== 1'b1 || pixel_cnt !== i[2:0]
             || line_pixel_count !== i[15:0] || sensor_pixel_vld_falling_edge !== 1'b0) begin
            err_cnt++;
            $display("FAIL line8_pix%0d: got data=%h vld=%b cnt=%0d lpc=%0d edge=%b, want data=%h vld=1 cnt=%0d lpc=%0d edge=0",
                     i, pixel_data, pixel_data_vld, pixel_cnt, line_pixel_count,
                     sensor_pixel_vld_falling_edge, 32'h100 + i, i, i);
         end
         if (i > 0) begin
            cmp_cnt++;
            if (pixel_data_d1 !== 32'h100 + i - 1) begin
               err_cnt++;
               $display("FAIL line8_d1_%0d: got %h want %h", i, pixel_data_d1, 32'h100 + i - 1);
            end
         end
      end
      sensor_pixel_vld = 1'b0;
      tick();
      cmp_cnt++;
      if (sensor_pixel_vld_falling_edge !== 1'b1 || line_done !== 1'b1 || pixel_cnt !== 3'd0
          || line_pixel_count !== 16'd8 || pixel_data_vld !== 1'b0) begin
         err_cnt++;
         $display("FAIL line8_edge: got edge=%b done=%b cnt=%0d lpc=%0d vld=%b, want 1 1 0 8 0",
                  sensor_pixel_vld_falling_edge, line_done, pixel_cnt, line_pixel_count, pixel_data_vld);
      end
      tick();
      cmp_cnt++;
      if (sensor_pixel_vld_falling_edge !== 1'b0 || pixel_data_d1 !== 32'h107 || line_pixel_count !== 16'd0) begin
         err_cnt++;
         $display("FAIL line8_after: got edge=%b d1=%h lpc=%0d, want edge=0 d1=107 lpc=0",
                  sensor_pixel_vld_falling_edge, pixel_data_d1, line_pixel_count);
      end
   endtask

   task automatic test_line5();
      for (int i = 0; i < 5; i++) begin
         sensor_pixel_vld = 1'b1;
         sensor_pixel_data = 32'h200 + i;
         tick();
      end
      sensor_pixel_vld = 1'b0;
      tick();
      cmp_cnt++;
      if (sensor_pixel_vld_falling_edge !== 1'b1 || pixel_cnt !== 3'd5 || line_pixel_count !== 16'd5) begin
         err_cnt++;
         $display("FAIL line5_edge: got edge=%b cnt=%0d lpc=%0d, want 1 5 5",
                  sensor_pixel_vld_falling_edge, pixel_cnt, line_pixel_count);
      end
      tick();
      cmp_cnt++;
      if (sensor_pixel_vld_falling_edge !== 1'b0 || pixel_cnt !== 3'd0 || line_pixel_count !== 16'd0) begin
         err_cnt++;
         $display("FAIL line5_clear: got edge=%b cnt=%0d lpc=%0d, want 0 0 0",
                  sensor_pixel_vld_falling_edge, pixel_cnt, line_pixel_count);
      end
   endtask

   task automatic test_back_to_back();
      int edges = 0;
      // pattern: 3 pixels, 1-cycle gap, 3 pixels, then idle
      for (int c = 0; c < 10; c++) begin
         sensor_pixel_vld = (c < 3) || (c >= 4 && c < 7);
         sensor_pixel_data = 32'h300 + c;
         tick();
         if (sensor_pixel_vld_falling_edge) edges++;
         if (c == 3) begin
            cmp_cnt++;
            if (sensor_pixel_vld_falling_edge !== 1'b1 || line_pixel_count !== 16'd3
                || pixel_cnt !== 3'd3 || pixel_data_d1 !== 32'h302) begin
               err_cnt++;
               $display("FAIL b2b_edge1: got edge=%b lpc=%0d cnt=%0d d1=%h, want 1 3 3 302",
                        sensor_pixel_vld_falling_edge, line_pixel_count, pixel_cnt, pixel_data_d1);
            end
         end
         if (c == 4) begin
            cmp_cnt++;
            if (pixel_data_vld !== 1'b1 || pixel_cnt !== 3'd0 || pixel_data !== 32'h304
                || line_pixel_count !== 16'd0) begin
               err_cnt++;
               $display("FAIL b2b_line2_first: got vld=%b cnt=%0d data=%h lpc=%0d, want 1 0 304 0",
                        pixel_data_vld, pixel_cnt, pixel_data, line_pixel_count);
            end
         end
         if (c == 7) begin
            cmp_cnt++;
            if (sensor_pixel_vld_falling_edge !== 1'b1 || line_pixel_count !== 16'd3) begin
               err_cnt++;
               $display("FAIL b2b_edge2: got edge=%b lpc=%0d, want 1 3",
                        sensor_pixel_vld_falling_edge, line_pixel_count);
            end
         end
      end
      cmp_cnt++;
      if (edges !== 2) begin
         err_cnt++;
         $display("FAIL b2b_edge_count: got %0d want 2", edges);
      end
   endtask

   task automatic test_line_len(input int npix, input logic exp_err);
      int errs = 0;
      int edge_lpc = -1;
      expected_line_pixels = 16'd640;
      for (int c = 0; c < npix + 3; c++) begin
         sensor_pixel_vld = (c < npix);
         sensor_pixel_data = 32'h4000 + c;
         tick();
         if (line_len_err) errs++;
         if (sensor_pixel_vld_falling_edge) edge_lpc = int'(line_pixel_count);
      end
      cmp_cnt++;
      if (errs !== int'(exp_err)) begin
         err_cnt++;
         $display("FAIL len_err_%0d: got %0d pulses want %0d", npix, errs, int'(exp_err));
      end
      cmp_cnt++;
      if (edge_lpc !== npix) begin
         err_cnt++;
         $display("FAIL len_lpc_%0d: got %0d want %0d", npix, edge_lpc, npix);
      end
   endtask

   task automatic test_enable_abort();
      int bad = 0;
      for (int i = 0; i < 4; i++) begin
         sensor_pixel_vld = 1'b1;
         sensor_pixel_data = 32'h500 + i;
         tick();
      end
      capture_enable = 1'b0;
      sensor_pixel_data = 32'h504;
      tick();
      cmp_cnt++;
      if ({pixel_data, pixel_data_d1, pixel_data_vld, pixel_cnt, sensor_pixel_vld_falling_edge,
           line_pixel_count, line_done, line_len_err} !== '0) begin
         err_cnt++;
         $display("FAIL abort_clear: got data=%h d1=%h vld=%b cnt=%0d lpc=%0d, want all 0",
                  pixel_data, pixel_data_d1, pixel_data_vld, pixel_cnt, line_pixel_count);
      end
      for (int i = 5; i < 12; i++) begin
         sensor_pixel_vld = (i < 10);
         sensor_pixel_data = 32'h500 + i;
         tick();
         if (sensor_pixel_vld_falling_edge || line_len_err || pixel_data_vld) bad++;
      end
      cmp_cnt++;
      if (bad !== 0) begin
         err_cnt++;
         $display("FAIL abort_quiet: got %0d active cycles want 0", bad);
      end
      capture_enable = 1'b1;
      for (int i = 0; i < 4; i++) begin
         sensor_pixel_vld = 1'b1;
         sensor_pixel_data = 32'h600 + i;
         tick();
         if (i == 0) begin
            cmp_cnt++;
            if (pixel_cnt !== 3'd0 || pixel_data !== 32'h600 || pixel_data_vld !== 1'b1) begin
               err_cnt++;
               $display("FAIL reenable_first: got cnt=%0d data=%h vld=%b, want 0 600 1",
                        pixel_cnt, pixel_data, pixel_data_vld);
            end
         end
      end
      sensor_pixel_vld = 1'b0;
      tick();
      cmp_cnt++;
      if (sensor_pixel_vld_falling_edge !== 1'b1 || pixel_cnt !== 3'd4 || line_pixel_count !== 16'd4) begin
         err_cnt++;
         $display("FAIL reenable_edge: got edge=%b cnt=%0d lpc=%0d, want 1 4 4",
                  sensor_pixel_vld_falling_edge, pixel_cnt, line_pixel_count);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_async_reset();
      test_line8();
      test_line5();
      test_back_to_back();
      test_line_len(639, CHK_EN);
      test_line_len(640, 1'b0);
      test_enable_abort();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

endmodule
